// File: rtl/traffic_ctrl_param.sv
// Two-road traffic-light controller with one-second prescaler, BCD countdown and night flash.
// Define ALL_RED_EN to compile in the all-red clearance phases between yellow and the opposite green.
module traffic_ctrl_param #(
  parameter int CLK_DIV   = 25000000,
  parameter int T_MAIN_G  = 60,
  parameter int T_MAIN_Y  = 4,
  parameter int T_SIDE_G  = 20,
  parameter int T_SIDE_Y  = 4,
  parameter int T_ALL_RED = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s,
  input  logic       night,
  output logic       MR,
  output logic       MY,
  output logic       MG,
  output logic       CR,
  output logic       CY,
  output logic       CG,
  output logic [7:0] cnt_bcd,
  output logic [2:0] state,
  output logic       sec_tick
);

  typedef enum logic [2:0] {
    MAIN_G   = 3'd0,
    MAIN_Y   = 3'd1,
    SIDE_G   = 3'd2,
    SIDE_Y   = 3'd3,
    FLASH    = 3'd4,
    ALLRED_A = 3'd5,
    ALLRED_B = 3'd6
  } state_t;

  // Lamp vector order: {MR, MY, MG, CR, CY, CG}.
  typedef struct packed {
    state_t     st;
    logic [7:0] cnt;
    logic [5:0] lamp;
  } ctl_t;

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(CLK_DIV - 1);

  function automatic logic [7:0] load(input int t);
    return {4'((t - 1) / 10), 4'((t - 1) % 10)};
  endfunction

  function automatic logic [7:0] dec(input logic [7:0] c);
    if (c[3:0] != 4'd0) return {c[7:4], c[3:0] - 4'd1};
    if (c[7:4] != 4'd0) return {c[7:4] - 4'd1, 4'd9};
    return c;
  endfunction

  // Everything that changes on a phase entry: new state, reloaded count, matching lamps.
  function automatic ctl_t enter(input state_t n);
    ctl_t r;
    r.st = n;
    case (n)
      MAIN_Y:   begin r.cnt = load(T_MAIN_Y);  r.lamp = 6'b010_100; end
      SIDE_G:   begin r.cnt = load(T_SIDE_G);  r.lamp = 6'b100_001; end
      SIDE_Y:   begin r.cnt = load(T_SIDE_Y);  r.lamp = 6'b100_010; end
      FLASH:    begin r.cnt = 8'h00;           r.lamp = 6'b010_010; end
      ALLRED_A,
      ALLRED_B: begin r.cnt = load(T_ALL_RED); r.lamp = 6'b100_100; end
      default:  begin r.st = MAIN_G; r.cnt = load(T_MAIN_G); r.lamp = 6'b001_100; end
    endcase
    return r;
  endfunction

  logic [PW-1:0] presc;
  ctl_t          ctl;
  logic          cnt_zero;

  assign cnt_zero = (ctl.cnt == 8'h00);

  // NOTE: state registers use non-blocking assignments and reset asynchronously on rst_n low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc    <= '0;
      sec_tick <= 1'b0;
    end else begin
      presc    <= (presc == PMAX) ? '0 : presc + 1'b1;
      sec_tick <= (presc == PMAX);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl <= enter(MAIN_G);
    end else if (sec_tick) begin
      if (night) begin
        if (ctl.st == FLASH)
          ctl.lamp <= {1'b0, ~ctl.lamp[4], 2'b00, ~ctl.lamp[1], 1'b0};
        else
          ctl <= enter(FLASH);
      end else begin
        case (ctl.st)
          MAIN_G: begin
            if (!cnt_zero)  ctl.cnt <= dec(ctl.cnt);
            else if (s)     ctl <= enter(MAIN_Y);
          end
          MAIN_Y: begin
`ifdef ALL_RED_EN
            if (cnt_zero)   ctl <= enter(ALLRED_A);
`else
            if (cnt_zero)   ctl <= enter(SIDE_G);
`endif
            else            ctl.cnt <= dec(ctl.cnt);
          end
          SIDE_G: begin
            if (!s || cnt_zero) ctl <= enter(SIDE_Y);
            else                ctl.cnt <= dec(ctl.cnt);
          end
          SIDE_Y: begin
`ifdef ALL_RED_EN
            if (cnt_zero)   ctl <= enter(ALLRED_B);
`else
            if (cnt_zero)   ctl <= enter(MAIN_G);
`endif
            else            ctl.cnt <= dec(ctl.cnt);
          end
          FLASH:            ctl <= enter(MAIN_G);
`ifdef ALL_RED_EN
          ALLRED_A: begin
            if (cnt_zero)   ctl <= enter(SIDE_G);
            else            ctl.cnt <= dec(ctl.cnt);
          end
          ALLRED_B: begin
            if (cnt_zero)   ctl <= enter(MAIN_G);
            else            ctl.cnt <= dec(ctl.cnt);
          end
`endif
          default:          ctl <= enter(MAIN_G);
        endcase
      end
    end
  end

  assign {MR, MY, MG, CR, CY, CG} = ctl.lamp;
  assign cnt_bcd = ctl.cnt;
  assign state   = ctl.st;

endmodule

// File: tb/tb_traffic_ctrl_param.sv
// Directed bench for traffic_ctrl_param: a CLK_DIV=1 instance for sequencing and a CLK_DIV=4
// instance for prescaler timing and asynchronous reset.
module tb_traffic_ctrl_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, s_a, night_a;
  logic       mr_a, my_a, mg_a, cr_a, cy_a, cg_a, tick_a;
  logic [7:0] cnt_a;
  logic [2:0] state_a;
  logic       rst_b, s_b, night_b;
  logic       mr_b, my_b, mg_b, cr_b, cy_b, cg_b, tick_b;
  logic [7:0] cnt_b;
  logic [2:0] state_b;

  wire [5:0] lamps_a = {mr_a, my_a, mg_a, cr_a, cy_a, cg_a};
  wire [5:0] lamps_b = {mr_b, my_b, mg_b, cr_b, cy_b, cg_b};

  traffic_ctrl_param #(.CLK_DIV(1), .T_MAIN_G(5), .T_MAIN_Y(4), .T_SIDE_G(20),
                       .T_SIDE_Y(4), .T_ALL_RED(2)) dut_a (
    .clk(clk), .rst_n(rst_a), .s(s_a), .night(night_a),
    .MR(mr_a), .MY(my_a), .MG(mg_a), .CR(cr_a), .CY(cy_a), .CG(cg_a),
    .cnt_bcd(cnt_a), .state(state_a), .sec_tick(tick_a));

  traffic_ctrl_param #(.CLK_DIV(4), .T_MAIN_G(3), .T_MAIN_Y(4), .T_SIDE_G(20),
                       .T_SIDE_Y(4), .T_ALL_RED(2)) dut_b (
    .clk(clk), .rst_n(rst_b), .s(s_b), .night(night_b),
    .MR(mr_b), .MY(my_b), .MG(mg_b), .CR(cr_b), .CY(cy_b), .CG(cg_b),
    .cnt_bcd(cnt_b), .state(state_b), .sec_tick(tick_b));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to_a(input logic [2:0] tgt, input int budget, input string tag);
    int n = 0;
    while (state_a !== tgt && n < budget) begin
      step();
      n++;
    end
    check(tag, 32'(state_a), 32'(tgt));
  endtask

  // Clearance phase after a yellow that has just expired; absent without ALL_RED_EN.
  task automatic clearance(input logic [2:0] ar, input string tag);
`ifdef ALL_RED_EN
    check({tag, "_st"}, 32'(state_a), 32'(ar));
    check({tag, "_lamps"}, 32'(lamps_a), 'b100_100);
    check({tag, "_cnt1"}, 32'(cnt_a), 'h01);
    step();
    check({tag, "_cnt0"}, 32'(cnt_a), 'h00);
    step();
`else
    check({tag, "_skipped"}, 32'(state_a == ar), 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_a = 1'b0; s_a = 1'b1; night_a = 1'b0;
    rst_b = 1'b0; s_b = 1'b1; night_b = 1'b0;
    repeat (2) step();

    check("rst_state", 32'(state_a), 0);
    check("rst_cnt",   32'(cnt_a),   'h04);
    check("rst_lamps", 32'(lamps_a), 'b001_100);
    check("rst_tick",  32'(tick_a),  0);

    rst_a = 1'b1;
    step();
    check("first_tick", 32'(tick_a), 1);
    check("first_cnt",  32'(cnt_a),  'h04);
    begin
      logic [7:0] seq [4] = '{8'h03, 8'h02, 8'h01, 8'h00};
      for (int i = 0; i < 4; i++) begin
        step();
        check($sformatf("mg_cnt%0d", i), 32'(cnt_a), 32'(seq[i]));
      end
    end
    step();
    check("my_state", 32'(state_a), 1);
    check("my_cnt",   32'(cnt_a),   'h03);
    check("my_lamps", 32'(lamps_a), 'b010_100);

    repeat (3) step();
    check("my_end", 32'(cnt_a), 'h00);
    step();
    clearance(3'd5, "ar_a");
    check("sg_state", 32'(state_a), 2);
    check("sg_cnt",   32'(cnt_a),   'h19);
    check("sg_lamps", 32'(lamps_a), 'b100_001);
    for (int i = 18; i >= 0; i--) begin
      step();
      check($sformatf("sg_cnt%0d", i), 32'(cnt_a), 32'({4'(i / 10), 4'(i % 10)}));
    end
    step();
    check("sy_state", 32'(state_a), 3);
    check("sy_cnt",   32'(cnt_a),   'h03);
    check("sy_lamps", 32'(lamps_a), 'b100_010);
    repeat (3) step();
    step();
    clearance(3'd6, "ar_b");
    check("back_mg_state", 32'(state_a), 0);
    check("back_mg_cnt",   32'(cnt_a),   'h04);
    check("back_mg_lamps", 32'(lamps_a), 'b001_100);

    s_a = 1'b0;
    repeat (4) step();
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("hold_state%0d", i), 32'(state_a), 0);
      check($sformatf("hold_cnt%0d", i),   32'(cnt_a),   'h00);
    end
    s_a = 1'b1;
    step();
    check("hold_exit_state", 32'(state_a), 1);
    check("hold_exit_cnt",   32'(cnt_a),   'h03);

    run_to_a(3'd2, 20, "reach_sg1");
    check("sg1_cnt", 32'(cnt_a), 'h19);
    repeat (7) step();
    check("sg1_at12", 32'(cnt_a), 'h12);
    s_a = 1'b0;
    step();
    check("early_state", 32'(state_a), 3);
    check("early_cy",    32'(cy_a),    1);
    check("early_cnt",   32'(cnt_a),   'h03);

    run_to_a(3'd0, 20, "reach_mg2");
    s_a = 1'b1;
    run_to_a(3'd2, 40, "reach_sg2");
    s_a = 1'b0;
    step();
    check("first_tick_exit", 32'(state_a), 3);

    s_a = 1'b1;
    run_to_a(3'd2, 40, "reach_sg3");
    step();
    check("sg3_cnt", 32'(cnt_a), 'h18);
    night_a = 1'b1;
    step();
    check("fl_state",  32'(state_a), 4);
    check("fl_cnt",    32'(cnt_a),   'h00);
    check("fl_lamps1", 32'(lamps_a), 'b010_010);
    step();
    check("fl_lamps0", 32'(lamps_a), 'b000_000);
    check("fl_state2", 32'(state_a), 4);
    step();
    check("fl_lamps1b", 32'(lamps_a), 'b010_010);
    night_a = 1'b0;
    step();
    check("fl_exit_state", 32'(state_a), 0);
    check("fl_exit_cnt",   32'(cnt_a),   'h04);
    check("fl_exit_lamps", 32'(lamps_a), 'b001_100);

    // Prescaler instance: tick every 4th cycle, first one four cycles after release.
    rst_b = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      check($sformatf("div4_tick%0d", i), 32'(tick_b), 32'(i % 4 == 0));
    end
    check("div4_cnt", 32'(cnt_b), 'h01);
    begin
      int n = 0;
      while (state_b !== 3'd1 && n < 40) begin
        step();
        n++;
      end
      check("div4_reach_my", 32'(state_b), 1);
    end
    repeat (5) step();
    check("div4_mid_my", 32'(cnt_b), 'h02);
    #3;
    rst_b = 1'b0;
    #1;
    check("async_state", 32'(state_b), 0);
    check("async_cnt",   32'(cnt_b),   'h02);
    check("async_lamps", 32'(lamps_b), 'b001_100);
    check("async_tick",  32'(tick_b),  0);
    step();
    rst_b = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      check($sformatf("rel_tick%0d", i), 32'(tick_b), 32'(i == 4));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
